// File: rtl/reg_file_wb.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_wb
//  Purpose  : Register file fed through a small write-back FIFO. Accepted
//             write-back requests are queued and drained into the register
//             array one entry per clock, strictly in acceptance order. Two
//             independent combinational read ports report the array value
//             and whether a queued, not-yet-drained write targets the
//             register being read.
//  Option   : `define WB_BYPASS_EN to forward the newest queued data for a
//             matching read address instead of flagging a hazard (the
//             HAZARD outputs are then tied low).
//  Ports    : CLK          - single clock, rising-edge active
//             RESET        - asynchronous, active-low reset
//             WB_VALID     - write-back request valid
//             WB_READY     - buffer can take a request this cycle
//             WB_ADDR      - destination register index
//             WB_DATA      - write data
//             OUT1ADDRESS  - read port 1 register index
//             OUT2ADDRESS  - read port 2 register index
//             REGOUT1/2    - read port data (combinational)
//             HAZARD1/2    - read port register has a queued write
//             PENDING      - number of occupied buffer entries
//  Revision : 1.0 - initial release
// ============================================================================
module reg_file_wb #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 8,
    parameter int WB_DEPTH = 2,   // power of two, >= 2
    localparam int ADDR_W  = $clog2(NUM_REGS),
    localparam int PTR_W   = $clog2(WB_DEPTH),
    localparam int CNT_W   = PTR_W + 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              WB_VALID,
    output logic              WB_READY,
    input  logic [ADDR_W-1:0] WB_ADDR,
    input  logic [DATA_W-1:0] WB_DATA,
    input  logic [ADDR_W-1:0] OUT1ADDRESS,
    input  logic [ADDR_W-1:0] OUT2ADDRESS,
    output logic [DATA_W-1:0] REGOUT1,
    output logic [DATA_W-1:0] REGOUT2,
    output logic              HAZARD1,
    output logic              HAZARD2,
    output logic [CNT_W-1:0]  PENDING
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] regs_q     [NUM_REGS];
    logic [DATA_W-1:0] regs_d     [NUM_REGS];
    logic [ADDR_W-1:0] buf_addr_q [WB_DEPTH];
    logic [ADDR_W-1:0] buf_addr_d [WB_DEPTH];
    logic [DATA_W-1:0] buf_data_q [WB_DEPTH];
    logic [DATA_W-1:0] buf_data_d [WB_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;

    logic              w_push;
    logic              w_pop;

    // Ready is gated by RESET directly so it drops the instant reset asserts.
    // A full buffer refuses a push even if the head drains on the same edge.
    assign WB_READY = RESET && (count_q < CNT_W'(WB_DEPTH));
    assign PENDING  = count_q;

    // ------------------------------------------------------------------
    // Next-state: FIFO push/pop and drain into the register array
    // ------------------------------------------------------------------
    always_comb begin
        w_push     = WB_VALID && WB_READY;
        w_pop      = (count_q != '0);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        regs_d     = regs_q;

        // Push never lands on the slot being popped: that would need a full
        // buffer, and a full buffer deasserts WB_READY.
        if (w_push) begin
            buf_addr_d[wr_ptr_q] = WB_ADDR;
            buf_data_d[wr_ptr_q] = WB_DATA;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end

        if (w_pop) begin
            regs_d[buf_addr_q[rd_ptr_q]] = buf_data_q[rd_ptr_q];
            rd_ptr_d                     = rd_ptr_q + PTR_W'(1);
        end

        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            regs_q     <= '{default: '0};
            buf_addr_q <= '{default: '0};
            buf_data_q <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            regs_q     <= regs_d;
            buf_addr_q <= buf_addr_d;
            buf_data_q <= buf_data_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // Entries are scanned from head (oldest) to tail (newest); a later hit
    // overrides an earlier one, so the newest matching entry wins. Only
    // occupied entries are considered, so a request being accepted this
    // cycle is never seen.
    // ------------------------------------------------------------------
    logic [PTR_W-1:0]  w_slot;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;
    logic              w_haz1;
    logic              w_haz2;

    always_comb begin
        w_rd1  = regs_q[OUT1ADDRESS];
        w_rd2  = regs_q[OUT2ADDRESS];
        w_haz1 = 1'b0;
        w_haz2 = 1'b0;
        w_slot = rd_ptr_q;
        for (int i = 0; i < WB_DEPTH; i++) begin
            w_slot = rd_ptr_q + PTR_W'(i);
            if (CNT_W'(i) < count_q) begin
`ifdef WB_BYPASS_EN
                if (buf_addr_q[w_slot] == OUT1ADDRESS) begin
                    w_rd1 = buf_data_q[w_slot];
                end
                if (buf_addr_q[w_slot] == OUT2ADDRESS) begin
                    w_rd2 = buf_data_q[w_slot];
                end
`else
                if (buf_addr_q[w_slot] == OUT1ADDRESS) begin
                    w_haz1 = 1'b1;
                end
                if (buf_addr_q[w_slot] == OUT2ADDRESS) begin
                    w_haz2 = 1'b1;
                end
`endif
            end
        end
    end

    assign REGOUT1 = w_rd1;
    assign REGOUT2 = w_rd2;

`ifdef WB_BYPASS_EN
    // Forwarding makes queued writes visible, so there is never a hazard.
    assign HAZARD1 = 1'b0;
    assign HAZARD2 = 1'b0;
    logic w_unused;
    assign w_unused = w_haz1 | w_haz2;
`else
    assign HAZARD1 = w_haz1;
    assign HAZARD2 = w_haz2;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_file_wb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_file_wb
//  Purpose  : Directed self-checking bench for reg_file_wb (default
//             parameters). Expectations follow WB_BYPASS_EN if it is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_wb;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       CLK;
    logic       RESET;
    logic       WB_VALID;
    logic       WB_READY;
    logic [2:0] WB_ADDR;
    logic [7:0] WB_DATA;
    logic [2:0] OUT1ADDRESS;
    logic [2:0] OUT2ADDRESS;
    logic [7:0] REGOUT1;
    logic [7:0] REGOUT2;
    logic       HAZARD1;
    logic       HAZARD2;
    logic [1:0] PENDING;

    int total;
    int bad;

    reg_file_wb #(
        .DATA_W   (8),
        .NUM_REGS (8),
        .WB_DEPTH (2)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .WB_VALID    (WB_VALID),
        .WB_READY    (WB_READY),
        .WB_ADDR     (WB_ADDR),
        .WB_DATA     (WB_DATA),
        .OUT1ADDRESS (OUT1ADDRESS),
        .OUT2ADDRESS (OUT2ADDRESS),
        .REGOUT1     (REGOUT1),
        .REGOUT2     (REGOUT2),
        .HAZARD1     (HAZARD1),
        .HAZARD2     (HAZARD2),
        .PENDING     (PENDING)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs and checks happen 1 time unit later.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [2:0] a, input logic [7:0] d);
        WB_VALID = 1'b1;
        WB_ADDR  = a;
        WB_DATA  = d;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        RESET = 1'b0;
        WB_VALID = 1'b0;
        WB_ADDR = '0;
        WB_DATA = '0;
        OUT1ADDRESS = 3'd3;
        OUT2ADDRESS = 3'd0;

        // ---------------- Reset state ----------------
        #2;
        chk("rst_ready",   WB_READY, 0);
        chk("rst_pending", PENDING,  0);
        chk("rst_haz1",    HAZARD1,  0);
        chk("rst_regout1", REGOUT1,  0);
        tick();
        tick();
        RESET = 1'b1;
        #1;
        chk("rel_ready", WB_READY, 1);

        // ---------------- Single write to r3 ----------------
        push(3'd3, 8'h5A);
        #1;
        chk("acc_not_haz", HAZARD1, 0);
        tick();
        WB_VALID = 1'b0;
        chk("sw_pending", PENDING, 1);
        chk("sw_haz1",    HAZARD1, BYP ? 0 : 1);
        chk("sw_regout1", REGOUT1, BYP ? 8'h5A : 8'h00);
        tick();
        chk("sw_done_regout1", REGOUT1, 8'h5A);
        chk("sw_done_haz1",    HAZARD1, 0);
        chk("sw_done_pending", PENDING, 0);

        // ---------------- Continuous stream of 4 ----------------
        OUT2ADDRESS = 3'd1;
        push(3'd1, 8'h11);
        #1; chk("st0_ready", WB_READY, 1);
        tick();
        chk("st0_pending", PENDING, 1);
        push(3'd2, 8'h22);
        #1; chk("st1_ready", WB_READY, 1);
        tick();
        // push+pop on the same edge: occupancy unchanged, head entry written
        chk("st1_pending", PENDING, 1);
        chk("st1_head_r1", REGOUT2, 8'h11);
        push(3'd4, 8'h44);
        #1; chk("st2_ready", WB_READY, 1);
        tick();
        chk("st2_pending", PENDING, 1);
        push(3'd5, 8'h55);
        #1; chk("st3_ready", WB_READY, 1);
        tick();
        chk("st3_pending", PENDING, 1);
        WB_VALID = 1'b0;
        tick();
        chk("st_drained", PENDING, 0);
        OUT1ADDRESS = 3'd1; OUT2ADDRESS = 3'd2; #1;
        chk("st_r1", REGOUT1, 8'h11);
        chk("st_r2", REGOUT2, 8'h22);
        OUT1ADDRESS = 3'd4; OUT2ADDRESS = 3'd5; #1;
        chk("st_r4", REGOUT1, 8'h44);
        chk("st_r5", REGOUT2, 8'h55);

        // ---------------- Same register twice ----------------
        OUT1ADDRESS = 3'd6;
        push(3'd6, 8'h10);
        tick();
        chk("sr0_haz",    HAZARD1, BYP ? 0 : 1);
        chk("sr0_regout", REGOUT1, BYP ? 8'h10 : 8'h00);
        push(3'd6, 8'h20);
        tick();
        WB_VALID = 1'b0;
        chk("sr1_haz",    HAZARD1, BYP ? 0 : 1);
        chk("sr1_regout", REGOUT1, BYP ? 8'h20 : 8'h10);
        tick();
        chk("sr2_haz",    HAZARD1, 0);
        chk("sr2_regout", REGOUT1, 8'h20);

        // ---------------- Dual read of r7 ----------------
        OUT1ADDRESS = 3'd7; OUT2ADDRESS = 3'd7;
        push(3'd7, 8'hFF);
        tick();
        WB_VALID = 1'b0;
        chk("dr0_haz1", HAZARD1, BYP ? 0 : 1);
        chk("dr0_haz2", HAZARD2, BYP ? 0 : 1);
        chk("dr0_out2", REGOUT2, BYP ? 8'hFF : 8'h00);
        tick();
        chk("dr1_out1", REGOUT1, 8'hFF);
        chk("dr1_out2", REGOUT2, 8'hFF);
        chk("dr1_haz1", HAZARD1, 0);
        chk("dr1_haz2", HAZARD2, 0);

        // ---------------- Inputs ignored without VALID ----------------
        OUT1ADDRESS = 3'd3;
        WB_VALID = 1'b0; WB_ADDR = 3'd3; WB_DATA = 8'hEE;
        tick();
        chk("nv_pending", PENDING, 0);
        chk("nv_regout",  REGOUT1, 8'h5A);

        // ---------------- Reset mid-operation ----------------
        OUT1ADDRESS = 3'd0; OUT2ADDRESS = 3'd7;
        push(3'd0, 8'h77);
        tick();
        chk("mr_pending_pre", PENDING, 1);
        RESET = 1'b0;
        #1;
        chk("mr_pending", PENDING, 0);
        chk("mr_ready",   WB_READY, 0);
        chk("mr_haz1",    HAZARD1, 0);
        chk("mr_r0",      REGOUT1, 0);
        chk("mr_r7",      REGOUT2, 0);
        tick();
        chk("mr_hold_pending", PENDING, 0);
        chk("mr_hold_r0",      REGOUT1, 0);
        RESET = 1'b1;
        push(3'd0, 8'h33);
        #1;
        chk("mr_rel_ready", WB_READY, 1);
        tick();
        WB_VALID = 1'b0;
        chk("mr_acc_pending", PENDING, 1);
        chk("mr_acc_r0",      REGOUT1, BYP ? 8'h33 : 8'h00);
        tick();
        chk("mr_final_r0",      REGOUT1, 8'h33);
        chk("mr_final_pending", PENDING, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
